// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared datapath definitions for the register-file write arbiter.
//   req_id_e      : requester identifier (REQ_A = ALU writeback,
//                   REQ_B = load writeback); also the mux-select encoding.
//   DEF_ADDR_W    : default register-address width.
//   DEF_DATA_W    : default write-data width.
//   DEF_CNT_W     : default conflict-counter width.
// ---------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a combinational grant and a registered
// last-grant pointer.
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_req_a   : requester A valid
//   i_req_b   : requester B valid
//   i_busy    : downstream cannot accept; suppresses both grants
//   o_gnt_a   : grant to A (same cycle as request)
//   o_gnt_b   : grant to B (same cycle as request)
// ---------------------------------------------------------------------------
module rr_arb2
    import rf_write_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_busy,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    req_id_e r_last_grant;
    logic    w_gnt_a;
    logic    w_gnt_b;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        // Reset is included so no handshake can complete while the block
        // is held in reset.
        if (i_rst_n && !i_busy) begin
            if (i_req_a && i_req_b) begin
                // Conflict: favour whoever did not win last time.
                w_gnt_a = (r_last_grant == REQ_B);
                w_gnt_b = (r_last_grant == REQ_A);
            end else begin
                w_gnt_a = i_req_a;
                w_gnt_b = i_req_b;
            end
        end
    end

    assign o_gnt_a = w_gnt_a;
    assign o_gnt_b = w_gnt_b;

    // Pointer starts at B so that A wins the first conflict after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= REQ_B;
        end else if (w_gnt_a) begin
            r_last_grant <= REQ_A;
        end else if (w_gnt_b) begin
            r_last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Arbitrates two writeback requesters (A = ALU, B = load) onto a single
// register-file write port with a one-cycle registered output stage.
//   i_clk, i_rst_n          : clock (rising edge), async active-low reset
//   i_a_valid/addr/data     : requester A write request
//   o_a_ready               : A accepted this cycle
//   i_b_valid/addr/data     : requester B write request
//   o_b_ready               : B accepted this cycle
//   i_rf_busy               : register file cannot take a write this cycle
//   o_wr_en/addr/data       : registered register-file write port
//   o_mux_sel               : registered select of last grant (0 = A, 1 = B)
//   o_conflict_cnt          : saturating count of cycles with both valid
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_valid,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_a_ready,
    input  logic              i_b_valid,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_b_ready,
    input  logic              i_rf_busy,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_mux_sel,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_xfer;
    req_id_e           w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    logic              r_wr_en_p1;
    logic [ADDR_W-1:0] r_wr_addr_p1;
    logic [DATA_W-1:0] r_wr_data_p1;
    req_id_e           r_mux_sel_p1;
    logic [CNT_W-1:0]  r_conflict_cnt;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req_a (i_a_valid),
        .i_req_b (i_b_valid),
        .i_busy  (i_rf_busy),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    // Grants are already qualified by valid, so a grant is a transfer.
    assign o_a_ready = w_gnt_a;
    assign o_b_ready = w_gnt_b;
    assign w_xfer    = w_gnt_a | w_gnt_b;
    assign w_sel     = w_gnt_b ? REQ_B : REQ_A;
    assign w_addr    = w_gnt_b ? i_b_addr : i_a_addr;
    assign w_data    = w_gnt_b ? i_b_data : i_a_data;

    // ---- stage p0 -> p1: registered write port ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en_p1   <= 1'b0;
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
            r_mux_sel_p1 <= REQ_A;
        end else begin
            // Register 0 is hardwired: accept the write but never enable it.
            r_wr_en_p1 <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_wr_addr_p1 <= w_addr;
                r_wr_data_p1 <= w_data;
                r_mux_sel_p1 <= w_sel;
            end
        end
    end

    // Conflicts are counted on demand, independent of rf_busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_conflict_cnt <= '0;
        end else if (i_a_valid && i_b_valid) begin
            r_conflict_cnt <= sat_inc(r_conflict_cnt);
        end
    end

    assign o_wr_en        = r_wr_en_p1;
    assign o_wr_addr      = r_wr_addr_p1;
    assign o_wr_data      = r_wr_data_p1;
    assign o_mux_sel      = r_mux_sel_p1;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mux_sel;
    logic [CNT_W-1:0]  conflict_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_a_valid      (a_valid),
        .i_a_addr       (a_addr),
        .i_a_data       (a_data),
        .o_a_ready      (a_ready),
        .i_b_valid      (b_valid),
        .i_b_addr       (b_addr),
        .i_b_data       (b_data),
        .o_b_ready      (b_ready),
        .i_rf_busy      (rf_busy),
        .o_wr_en        (wr_en),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_mux_sel      (mux_sel),
        .o_conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic ea, input logic eb);
        chk({tag, ".a_ready"}, 64'(a_ready), 64'(ea));
        chk({tag, ".b_ready"}, 64'(b_ready), 64'(eb));
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [ADDR_W-1:0] ad,
                          input logic [DATA_W-1:0] da, input logic sel);
        chk({tag, ".wr_en"},   64'(wr_en),   64'(en));
        chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(ad));
        chk({tag, ".wr_data"}, 64'(wr_data), 64'(da));
        chk({tag, ".mux_sel"}, 64'(mux_sel), 64'(sel));
    endtask

    initial begin
        // Reset with requests present: nothing may be accepted.
        rst_n = 1'b0; rf_busy = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
        repeat (2) tick();
        chk_rdy("reset", 1'b0, 1'b0);
        chk_wr("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("reset.cnt", 64'(conflict_cnt), 64'd0);

        // Single A write, first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1; b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
        #1 chk_rdy("singleA", 1'b1, 1'b0);
        tick();
        a_valid = 1'b0;
        chk_wr("singleA", 1'b1, 5'd5, 32'h1234, 1'b0);
        tick();
        chk_wr("singleA.idle", 1'b0, 5'd5, 32'h1234, 1'b0);

        // B write to register 0: accepted, no enable.
        @(negedge clk);
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hBEEF;
        #1 chk_rdy("zeroB", 1'b0, 1'b1);
        tick();
        b_valid = 1'b0;
        chk_wr("zeroB", 1'b0, 5'd0, 32'hBEEF, 1'b1);

        // Conflicts alternate A,B,A,B then lone A; one write every cycle.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        #1 chk_rdy("rr1", 1'b1, 1'b0);
        tick();
        chk_wr("rr1", 1'b1, 5'd1, 32'h11, 1'b0);
        chk("rr1.cnt", 64'(conflict_cnt), 64'd1);
        a_addr = 5'd3; a_data = 32'h33;
        chk_rdy("rr2", 1'b0, 1'b1);
        tick();
        chk_wr("rr2", 1'b1, 5'd2, 32'h22, 1'b1);
        b_addr = 5'd4; b_data = 32'h44;
        chk_rdy("rr3", 1'b1, 1'b0);
        tick();
        chk_wr("rr3", 1'b1, 5'd3, 32'h33, 1'b0);
        a_addr = 5'd5; a_data = 32'h55;
        chk_rdy("rr4", 1'b0, 1'b1);
        tick();
        chk_wr("rr4", 1'b1, 5'd4, 32'h44, 1'b1);
        chk("rr4.cnt", 64'(conflict_cnt), 64'd4);
        b_valid = 1'b0;
        chk_rdy("rr5", 1'b1, 1'b0);
        tick();
        chk_wr("rr5", 1'b1, 5'd5, 32'h55, 1'b0);
        chk("rr5.cnt", 64'(conflict_cnt), 64'd4);

        // Busy stalls A for three cycles, then one write.
        a_addr = 5'd7; a_data = 32'h77; rf_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_rdy("busy", 1'b0, 1'b0);
            tick();
            chk_wr("busy", 1'b0, 5'd5, 32'h55, 1'b0);
        end
        rf_busy = 1'b0;
        #1 chk_rdy("unbusy", 1'b1, 1'b0);
        tick();
        a_valid = 1'b0;
        chk_wr("unbusy", 1'b1, 5'd7, 32'h77, 1'b0);
        chk("unbusy.cnt", 64'(conflict_cnt), 64'd4);
        tick();
        chk("unbusy.single", 64'(wr_en), 64'd0);

        // Conflict while busy still counts.
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1; rf_busy = 1'b1;
        #1 chk_rdy("busyconf", 1'b0, 1'b0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0; rf_busy = 1'b0;
        chk("busyconf.cnt", 64'(conflict_cnt), 64'd5);
        chk("busyconf.wr_en", 64'(wr_en), 64'd0);

        // Accept A (pointer -> A), then reset pulse cancels the write.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
        #1 chk_rdy("prerst", 1'b1, 1'b0);
        tick();
        a_valid = 1'b0;
        chk("prerst.wr_en", 64'(wr_en), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_wr("midrst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("midrst.cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
        #1 chk_rdy("postrst", 1'b1, 1'b0);
        tick();
        chk_wr("postrst", 1'b1, 5'd8, 32'h88, 1'b0);

        // Saturation of the conflict counter.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        rf_busy = 1'b1;
        repeat (254) @(posedge clk);
        #1 chk("sat.254", 64'(conflict_cnt), 64'd254);
        tick();
        chk("sat.255", 64'(conflict_cnt), 64'd255);
        repeat (6) tick();
        chk("sat.hold", 64'(conflict_cnt), 64'd255);
        a_valid = 1'b0; b_valid = 1'b0; rf_busy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter DATA_W, default 32, write-data width.
REQ-003 Parameter CNT_W, default 8, conflict-counter width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 a_addr  input  ADDR_W  requester A destination register.
REQ-008 a_data  input  DATA_W  requester A write data.
REQ-009 a_ready  output  1  requester A accepted this cycle.
REQ-010 b_valid  input  1  requester B (load writeback) has a write pending.
REQ-011 b_addr  input  ADDR_W  requester B destination register.
REQ-012 b_data  input  DATA_W  requester B write data.
REQ-013 b_ready  output  1  requester B accepted this cycle.
REQ-014 rf_busy  input  1  register file cannot accept a write this cycle.
REQ-015 wr_en  output  1  register-file write enable, registered.
REQ-016 wr_addr  output  ADDR_W  register-file write address, registered.
REQ-017 wr_data  output  DATA_W  register-file write data, registered.
REQ-018 mux_sel  output  1  select for the team's 2:1 address/data muxes; 0 = A, 1 = B; registered; reflects the last grant.
REQ-019 conflict_cnt  output  CNT_W  count of cycles in which both requesters were valid.

Function
REQ-020 Grant SHALL be decided combinationally each cycle from a_valid, b_valid, rf_busy and the last_grant register.
REQ-021 When rf_busy=1, a_ready=0 and b_ready=0.
REQ-022 When rf_busy=0 and only one requester is valid, that requester's ready SHALL be 1 in the same cycle.
REQ-023 When rf_busy=0 and both are valid, the requester not named by last_grant SHALL be granted (round-robin); the other's ready SHALL be 0.
REQ-024 At most one of a_ready/b_ready SHALL be 1 in any cycle; ready SHALL never be 1 while the matching valid is 0.
REQ-025 A transfer occurs when valid and ready are both 1; last_grant SHALL update to the granted requester on that edge.
REQ-026 Requesters SHALL hold valid, addr and data stable until ready; the block does not buffer unaccepted requests.
REQ-027 On a transfer, wr_addr, wr_data and mux_sel SHALL load the granted values on the next edge (latency 1 cycle).
REQ-028 On a transfer, wr_en SHALL be 1 for exactly the following cycle, except for a write with addr=0, which is accepted (ready=1) but produces wr_en=0.
REQ-029 In cycles with no transfer, wr_en SHALL be 0; wr_addr, wr_data and mux_sel SHALL hold their previous values.
REQ-030 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-031 conflict_cnt SHALL increment when a_valid=1 and b_valid=1, regardless of rf_busy; it saturates at all-ones and does not wrap.

Reset
REQ-032 While Rst_n=0: wr_en=0, wr_addr=0, wr_data=0, mux_sel=0, conflict_cnt=0, last_grant=B (so A wins the first conflict).
REQ-033 Asserting Rst_n mid-operation SHALL cancel any registered write immediately (wr_en=0 asynchronously); a_ready and b_ready SHALL be 0 during reset.
REQ-034 First transfer is possible on the first rising edge after Rst_n deasserts.

Structure
REQ-035 Requester-ID constants (REQ_A=0, REQ_B=1) and default ADDR_W/DATA_W SHALL live in the shared datapath package.
REQ-036 Grant logic SHALL be one sub-module rr_arb2 (two-way round-robin, combinational grant, registered pointer); the output stage and counter stay in the top.

Verification
REQ-037 Reset, then a_valid=1, a_addr=5, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x1234, mux_sel=0.
REQ-038 Both valid for 4 cycles with distinct addrs 1..4, rf_busy=0 -> grants alternate A,B,A,B; wr_en=1 for 4 consecutive cycles; conflict_cnt=4 (or fewer once one side drops).
REQ-039 b_valid=1, b_addr=0 -> b_ready=1; next cycle wr_en=0, mux_sel=1, wr_addr=0.
REQ-040 a_valid=1 with rf_busy=1 for 3 cycles then 0 -> a_ready=0 for 3 cycles, then 1; exactly one write follows; conflict_cnt unchanged.
REQ-041 Transfer accepted, Rst_n pulsed low before the next edge -> wr_en=0 immediately and all outputs zero; the next conflict grants A.
REQ-042 Both valid held for 2^CNT_W+5 cycles -> conflict_cnt saturates at all-ones.
